// File: rtl/clb_array_cfg.sv
// Configurable logic block: N BLEs (K-input LUT + FF, 2-bit mode) loaded over a serial
// valid/ready config chain. Define CLB_CFG_READBACK_EN to expose the chain MSB on cfg_dout.
module clb_array_cfg #(
  parameter int K = 5,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_din,
  output logic           cfg_ready,
  output logic           cfg_done,
  output logic           cfg_dout,
  input  logic           ce,
  input  logic [N*K-1:0] data_in,
  output logic [N-1:0]   data_out
);

  localparam int L  = 1 << K;
  localparam int B  = L + 2;
  localparam int T  = N * B;
  localparam int CW = $clog2(T + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [T-1:0]  chain_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          last_bit;

  // A start in the same cycle as a valid bit wins, so the bit is dropped.
  assign accept   = cfg_valid && (state_q == LOAD) && !cfg_start;
  assign last_bit = accept && (cnt_q == CW'(T - 1));

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = LOAD;
      LOAD:    if (last_bit)  state_d = DONE;
      DONE:    if (cfg_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_start)   cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: the chain is a plain shift register, not a memory, so it is reset to a known
  // all-zero bitstream; that also keeps readback of an unloaded block deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chain_q <= '0;
    else if (accept) chain_q <= {chain_q[T-2:0], cfg_din};
  end

  assign cfg_ready = (state_q == LOAD);
  assign cfg_done  = (state_q == DONE);

`ifdef CLB_CFG_READBACK_EN
  assign cfg_dout = chain_q[T-1];
`else
  assign cfg_dout = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ble
    logic [1:0]   mode;
    logic [L-1:0] lut;
    logic         f;
    logic         ff_q;
    logic         out;

    assign mode = chain_q[i*B + B - 1 -: 2];
    assign lut  = chain_q[i*B +: L];
    assign f    = lut[data_in[i*K +: K]];

    // cfg_start always enters (or stays in) LOAD, and FFs only move in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ff_q <= 1'b0;
      end else if (cfg_start) begin
        ff_q <= 1'b0;
      end else if (state_q == DONE) begin
        if (mode == 2'b01 || (mode == 2'b10 && ce)) ff_q <= f;
      end
    end

    always_comb begin
      out = 1'b0;
      if (state_q == DONE) begin
        unique case (mode)
          2'b00:   out = f;
          2'b01:   out = ff_q;
          2'b10:   out = ff_q;
          default: out = 1'b0;
        endcase
      end
    end

    assign data_out[i] = out;
  end

endmodule
